// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: active-low 7-segment patterns (gfedcba), blank pattern, digit max, encoder helper
package bcd_disp_pkg;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  function automatic logic [6:0] seg_pattern(input logic [3:0] d, input logic blank, input logic active_low);
    logic [6:0] p;
    case (d)
      4'd0: p = SEG_0;
      4'd1: p = SEG_1;
      4'd2: p = SEG_2;
      4'd3: p = SEG_3;
      4'd4: p = SEG_4;
      4'd5: p = SEG_5;
      4'd6: p = SEG_6;
      4'd7: p = SEG_7;
      4'd8: p = SEG_8;
      4'd9: p = SEG_9;
      default: p = SEG_BLANK;
    endcase
    p = blank ? SEG_BLANK : p;
    return active_low ? p : ~p;
  endfunction
endpackage

// File: rtl/bcd_seg7_enc.sv
// bcd_seg7_enc: one BCD nibble + blank flag -> 7 segment bits (gfedcba)
//   i_bcd   : BCD digit
//   i_blank : force all segments off
//   o_seg   : segment bits, polarity set by ACTIVE_LOW (1 = lit by 0)
module bcd_seg7_enc
  import bcd_disp_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);
  assign o_seg = seg_pattern(i_bcd, i_blank, ACTIVE_LOW != 0);
endmodule

// File: rtl/bcd_updown_display.sv
// bcd_updown_display: NDIGITS BCD up/down counter with edge-detected inc/dec, load and registered 7-seg outputs
//   clk, reset (sync, active-high), inc/dec (level, count on rise), load/load_value (packed BCD, nibbles >9 stored as 0)
//   bcd_out (registered count), seg_out (registered gfedcba per digit), overflow/underflow (one-cycle wrap pulses)
//   Optional macro LEADING_ZERO_BLANK_EN: blank zero digits above the highest nonzero digit (digit 0 never blanked)
module bcd_updown_display
  import bcd_disp_pkg::*;
#(
  parameter int NDIGITS    = 6,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inc,
  input  logic                   dec,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   load_value,
  output logic [4*NDIGITS-1:0]   bcd_out,
  output logic [7*NDIGITS-1:0]   seg_out,
  output logic                   overflow,
  output logic                   underflow
);
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  localparam int W = 4 * NDIGITS;
  logic                 r_inc_q, r_dec_q, r_ovf, r_unf;
  logic [W-1:0]         r_bcd;
  logic [7*NDIGITS-1:0] r_seg;
  logic                 w_up, w_down;
  logic [W-1:0]         w_bcd_inc, w_bcd_dec, w_load_clean;
  logic [NDIGITS:0]     w_carry, w_borrow;
  logic [NDIGITS-1:0]   w_blank;
  logic [7*NDIGITS-1:0] w_seg, w_seg_zero;
  // simultaneous rises cancel each other
  assign w_up   = (inc & ~r_inc_q) & ~(dec & ~r_dec_q);
  assign w_down = (dec & ~r_dec_q) & ~(inc & ~r_inc_q);
  assign w_carry[0]  = 1'b1;
  assign w_borrow[0] = 1'b1;
  for (genvar k = 0; k < NDIGITS; k++) begin : g_dig
    logic [3:0] w_d, w_lv;
    assign w_d  = r_bcd[4*k +: 4];
    assign w_lv = load_value[4*k +: 4];
    // ripple carry/borrow: a digit moves only when every lower digit wraps
    assign w_bcd_inc[4*k +: 4] = !w_carry[k] ? w_d : (w_d == DIGIT_MAX) ? 4'd0 : w_d + 4'd1;
    assign w_carry[k+1]        = w_carry[k] & (w_d == DIGIT_MAX);
    assign w_bcd_dec[4*k +: 4] = !w_borrow[k] ? w_d : (w_d == 4'd0) ? DIGIT_MAX : w_d - 4'd1;
    assign w_borrow[k+1]       = w_borrow[k] & (w_d == 4'd0);
    assign w_load_clean[4*k +: 4] = (w_lv > DIGIT_MAX) ? 4'd0 : w_lv;
    // blank when this and every higher digit is zero
    assign w_blank[k] = LZB && (k > 0) && (r_bcd[W-1:4*k] == '0);
    assign w_seg_zero[7*k +: 7] = seg_pattern(4'd0, LZB && (k > 0), ACTIVE_LOW != 0);
    bcd_seg7_enc #(.ACTIVE_LOW(ACTIVE_LOW)) u_enc (
      .i_bcd  (w_d),
      .i_blank(w_blank[k]),
      .o_seg  (w_seg[7*k +: 7])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bcd   <= '0;
      r_seg   <= w_seg_zero;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_inc_q <= 1'b1;
      r_dec_q <= 1'b1;
    end else begin
      r_inc_q <= inc;
      r_dec_q <= dec;
      r_seg   <= w_seg;
      r_bcd   <= load ? w_load_clean : w_up ? w_bcd_inc : w_down ? w_bcd_dec : r_bcd;
      r_ovf   <= !load && w_up && w_carry[NDIGITS];
      r_unf   <= !load && w_down && w_borrow[NDIGITS];
    end
  end
  assign bcd_out   = r_bcd;
  assign seg_out   = r_seg;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
endmodule
